// File: rtl/result_checker.sv
// result_checker: in-order scoreboard comparing a Result stream against a preloaded table of expected values.
module result_checker #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_CHECKS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic [DATA_W-1:0] result,
    input  logic              result_valid,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    pass_count,
    output logic [IDX_W:0]    fail_count,
    output logic              mismatch,
    output logic              first_fail_valid,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_value
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHECKS - 1);
    state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] exp_mem [2**IDX_W];
    logic launch, cmp, hit;
    always_comb begin
        launch   = state != RUN && start;
        cmp      = state == RUN && result_valid;
        hit      = result == exp_mem[idx];
        state_nx = launch ? RUN : (cmp && idx == LAST) ? DONE : state;
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    // Table has no reset; writes are locked out while a run is comparing against it
    always_ff @(posedge clk)
        if (exp_we && state != RUN && 32'(exp_addr) < NUM_CHECKS) exp_mem[exp_addr] <= exp_data;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx              <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            mismatch         <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_value <= '0;
        end else begin
            mismatch <= cmp && !hit;
            if (launch) begin
                idx              <= '0;
                pass_count       <= '0;
                fail_count       <= '0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= '0;
                first_fail_value <= '0;
            end else if (cmp) begin
                idx <= idx + 1'b1;
                if (hit) pass_count <= pass_count + 1'b1;
                else begin
                    fail_count <= fail_count + 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                        first_fail_value <= result;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: directed runs against result_checker with a per-cycle reference model and literal end-of-run checks.
module tb_result_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        start = 1'b0;
    logic [31:0] result = '0;
    logic        result_valid = 1'b0;
    logic        busy, done, mismatch, first_fail_valid;
    logic [5:0]  pass_count, fail_count;
    logic [4:0]  first_fail_idx;
    logic [31:0] first_fail_value;

    result_checker #(.DATA_W(32), .IDX_W(5), .NUM_CHECKS(20)) dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .result(result), .result_valid(result_valid), .busy(busy), .done(done),
        .pass_count(pass_count), .fail_count(fail_count), .mismatch(mismatch),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .first_fail_value(first_fail_value)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc_n = 0, mm_cnt = 0;
    bit chk_en = 1'b0;
    logic [31:0] golden [20] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hB, 32'h3,
        32'hFFFF_FFFE, 32'h0, 32'h5, 32'h1, 32'hFFFF_FFF4, 32'h4D2, 32'hFFFF_F8D7, 32'h1,
        32'hFFFF_FB2C, 32'h30, 32'h30};

    // Reference: phase 0 idle, 1 running, 2 finished; outcome of each compare tallied directly
    int          m_ph = 0, m_idx = 0, m_pass = 0, m_fail = 0, m_ffi = 0;
    bit          m_mm = 1'b0, m_ffv = 1'b0;
    logic [31:0] m_ffval = '0;
    logic [31:0] m_tab [32];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph <= 0; m_idx <= 0; m_pass <= 0; m_fail <= 0; m_ffi <= 0;
            m_mm <= 1'b0; m_ffv <= 1'b0; m_ffval <= '0;
        end else begin
            m_mm <= 1'b0;
            if (m_ph != 1 && exp_we && exp_addr < 20) m_tab[exp_addr] <= exp_data;
            if (m_ph != 1 && start) begin
                m_ph <= 1; m_idx <= 0; m_pass <= 0; m_fail <= 0;
                m_ffv <= 1'b0; m_ffi <= 0; m_ffval <= '0;
            end else if (m_ph == 1 && result_valid) begin
                if (result == m_tab[m_idx]) m_pass <= m_pass + 1;
                else begin
                    m_fail <= m_fail + 1;
                    m_mm <= 1'b1;
                    if (!m_ffv) begin m_ffv <= 1'b1; m_ffi <= m_idx; m_ffval <= result; end
                end
                m_idx <= m_idx + 1;
                if (m_idx == 19) m_ph <= 2;
            end
        end
    end

    always @(negedge clk) begin
        if (mismatch) mm_cnt++;
        if (chk_en) begin
            n_cmp++;
            if (busy !== (m_ph == 1) || done !== (m_ph == 2) || pass_count !== 6'(m_pass) ||
                fail_count !== 6'(m_fail) || mismatch !== m_mm || first_fail_valid !== m_ffv ||
                first_fail_idx !== 5'(m_ffi) || first_fail_value !== m_ffval) begin
                n_bad++;
                $display("FAIL model cycle %0d: got busy=%b done=%b pass=%0d fail=%0d mm=%b ffv=%b ffi=%0d ffval=%h, want busy=%b done=%b pass=%0d fail=%0d mm=%b ffv=%b ffi=%0d ffval=%h",
                    cyc_n, busy, done, pass_count, fail_count, mismatch, first_fail_valid, first_fail_idx,
                    first_fail_value, m_ph == 1, m_ph == 2, m_pass, m_fail, m_mm, m_ffv, m_ffi, m_ffval);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Stream 20 values after a start pulse; stalls inserted after indices s_at/s2_at.
    // lat = edges from the start-sampling edge to the first cycle done is visible.
    task automatic run(input logic [31:0] v [20], input int s_at, input int s_len,
                       input int s2_at, input int s2_len, input int inj_at, output int lat);
        int t0;
        @(negedge clk) start = 1'b1;
        t0 = cyc_n + 1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            result = v[i]; result_valid = 1'b1;
            if (i == inj_at) begin start = 1'b1; exp_we = 1'b1; exp_addr = 5'd0; exp_data = 32'hDEAD; end
            @(negedge clk);
            result_valid = 1'b0; start = 1'b0; exp_we = 1'b0;
            if (i == s_at) repeat (s_len) @(negedge clk);
            if (i == s2_at) repeat (s2_len) @(negedge clk);
        end
        for (int k = 0; k < 50 && !done; k++) @(negedge clk);
        check("done_reached", 32'(done), 32'd1);
        lat = cyc_n - t0;
    endtask

    initial begin
        int lat;
        logic [31:0] v [20];
        mm_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, pass_count, fail_count, mismatch, first_fail_valid, first_fail_idx}, 0);
        reset = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) exp_we = 1'b1; exp_addr = 5'(i); exp_data = golden[i];
        end
        @(negedge clk) exp_we = 1'b0;

        // 1: all correct, back-to-back
        mm_cnt = 0;
        run(golden, -1, 0, -1, 0, -1, lat);
        check("s1_latency", lat, 20);
        check("s1_pass", 32'(pass_count), 20);
        check("s1_fail", 32'(fail_count), 0);
        check("s1_ffv", 32'(first_fail_valid), 0);
        check("s1_mm_pulses", mm_cnt, 0);
        check("s1_busy", 32'(busy), 0);

        // 2: two wrong values
        v = golden; v[9] = 32'hFFFF_FFFF; v[14] = 32'h0;
        mm_cnt = 0;
        run(v, -1, 0, -1, 0, -1, lat);
        check("s2_pass", 32'(pass_count), 18);
        check("s2_fail", 32'(fail_count), 2);
        check("s2_ffi", 32'(first_fail_idx), 9);
        check("s2_ffval", first_fail_value, 32'hFFFF_FFFF);
        check("s2_mm_pulses", mm_cnt, 2);

        // 3: stalls of 3 and 1 cycles
        run(golden, 4, 3, 12, 1, -1, lat);
        check("s3_latency", lat, 24);
        check("s3_pass", 32'(pass_count), 20);

        // 4: start and table write during RUN are ignored; a rerun from DONE still matches entry 0
        run(golden, -1, 0, -1, 0, 5, lat);
        check("s4_pass", 32'(pass_count), 20);
        check("s4_latency", lat, 20);
        run(golden, -1, 0, -1, 0, -1, lat);
        check("s4_rerun_pass", 32'(pass_count), 20);

        // 5: asynchronous reset mid-run
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            result = golden[i]; result_valid = 1'b1;
            @(negedge clk);
        end
        check("s5_busy_before", 32'(busy), 1);
        #2 reset = 1'b0;
        #1 check("s5_async_clear", {busy, done, pass_count, fail_count, mismatch, first_fail_valid, first_fail_idx, first_fail_value}, 0);
        result_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run(golden, -1, 0, -1, 0, -1, lat);
        check("s5_rerun_pass", 32'(pass_count), 20);

        // 6: out-of-range write ignored; every result wrong
        @(negedge clk) exp_we = 1'b1; exp_addr = 5'd25; exp_data = 32'h1234;
        @(negedge clk) exp_we = 1'b0;
        for (int i = 0; i < 20; i++) v[i] = ~golden[i];
        run(v, -1, 0, -1, 0, -1, lat);
        check("s6_fail", 32'(fail_count), 20);
        check("s6_pass", 32'(pass_count), 0);
        check("s6_ffi", 32'(first_fail_idx), 0);
        check("s6_ffval", first_fail_value, 32'hFFFF_FFFF);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
